// File: rtl/spi_dma_pkg.sv
// Shared definitions for the DMA-stream-to-SPI transmitter: FSM encoding, word width, bit order.
// Bit order within a byte is LSB-first when SPI_DMA_TX_LSB_FIRST_EN is defined, MSB-first otherwise.
package spi_dma_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t SETUP = 3'd1;
    localparam state_t SHIFT = 3'd2;
    localparam state_t NEXT  = 3'd3;
    localparam state_t HOLD  = 3'd4;

    function automatic int dwFromAl(input int al);
        return 8 * (2 ** al);
    endfunction

    localparam int DW_DEFAULT = dwFromAl(2);

    // Maps the serial position within a byte to the data bit it carries.
    function automatic logic [2:0] bitInByte(input logic [2:0] pos);
`ifdef SPI_DMA_TX_LSB_FIRST_EN
        return pos;
`else
        return ~pos;
`endif
    endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// Loadable down-counter: ticks once every i_div+1 cycles, reloading on i_restart.
module spi_sclk_div
    import spi_dma_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] i_div,
    input  logic          i_restart,
    output logic          o_tick
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == '0)) begin
            r_cnt <= i_div;
        end else begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/spi_dma_tx.sv
// Serializes DMA stream words onto a mode-0 SPI master link, little-endian byte order.
// Define SPI_DMA_TX_LSB_FIRST_EN to send bits within each byte LSB-first.
module spi_dma_tx
    import spi_dma_pkg::*;
#(
    parameter int AL = 2,
    parameter int CW = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CW-1:0]          cfg_div,
    input  logic                   dma_val,
    output logic                   dma_rdy,
    input  logic [8*(2**AL)-1:0]   dma_d,
    input  logic                   dma_eof,
    output logic                   spi_cs_n,
    output logic                   spi_sclk,
    output logic                   spi_mosi,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int DW = dwFromAl(AL);
    localparam int BW = AL + 3;

    state_t        r_state;
    logic [DW-1:0] r_word;
    logic          r_eof;
    logic [CW-1:0] r_div;
    logic [BW-1:0] r_bitCnt;
    logic          r_phase;
    logic          r_holdArm;
    logic          r_csN;
    logic          r_sclk;
    logic          r_mosi;
    logic          r_rdy;
    logic          r_busy;
    logic          r_done;

    state_t        w_nState;
    logic [DW-1:0] w_nWord;
    logic          w_nEof;
    logic [CW-1:0] w_nDiv;
    logic [BW-1:0] w_nBitCnt;
    logic          w_nPhase;
    logic          w_nSclk;
    logic          w_nMosi;
    logic          w_accept;
    logic          w_tickRaw;
    logic          w_tick;
    logic          w_holdFirst;
    logic          w_restart;
    logic [CW-1:0] w_divSel;
    logic [BW-1:0] w_bitNext;
    logic [BW-1:0] w_idx0;
    logic [BW-1:0] w_idxNext;

    assign w_accept    = dma_val && r_rdy;
    assign w_holdFirst = (r_state == HOLD) && !r_holdArm;
    assign w_tick      = w_tickRaw && !w_holdFirst;
    assign w_bitNext   = r_bitCnt + BW'(1);
    assign w_idx0      = BW'(bitInByte(3'd0));
    assign w_idxNext   = {w_bitNext[BW-1:3], bitInByte(w_bitNext[2:0])};
    // HOLD re-arms the divider once after entry, giving the sclk-return cycle before the T hold cycles.
    assign w_restart   = (w_nState != r_state) || w_holdFirst;
    assign w_divSel    = (r_state == IDLE) ? cfg_div : r_div;

    spi_sclk_div #(.CW(CW)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_div     (w_divSel),
        .i_restart (w_restart),
        .o_tick    (w_tickRaw)
    );

    always_comb begin
        w_nState  = r_state;
        w_nWord   = r_word;
        w_nEof    = r_eof;
        w_nDiv    = r_div;
        w_nBitCnt = r_bitCnt;
        w_nPhase  = r_phase;
        w_nSclk   = r_sclk;
        w_nMosi   = r_mosi;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nState  = SETUP;
                    w_nWord   = dma_d;
                    w_nEof    = dma_eof;
                    w_nDiv    = cfg_div;
                    w_nBitCnt = '0;
                    w_nPhase  = 1'b0;
                    w_nMosi   = dma_d[w_idx0];
                end
            end
            SETUP: begin
                if (w_tick) begin
                    w_nState = SHIFT;
                    w_nPhase = 1'b0;
                end
            end
            SHIFT: begin
                if (w_tick) begin
                    if (!r_phase) begin
                        w_nPhase = 1'b1;
                        w_nSclk  = 1'b1;
                    end else begin
                        w_nPhase  = 1'b0;
                        w_nSclk   = 1'b0;
                        w_nBitCnt = w_bitNext;
                        if (r_bitCnt == '1) begin
                            w_nState = r_eof ? HOLD : NEXT;
                        end else begin
                            w_nMosi = r_word[w_idxNext];
                        end
                    end
                end
            end
            NEXT: begin
                if (w_accept) begin
                    w_nState  = SHIFT;
                    w_nWord   = dma_d;
                    w_nEof    = dma_eof;
                    w_nBitCnt = '0;
                    w_nPhase  = 1'b0;
                    w_nMosi   = dma_d[w_idx0];
                end
            end
            HOLD: begin
                if (w_tick) begin
                    w_nState = IDLE;
                end
            end
            default: w_nState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_word    <= '0;
            r_eof     <= 1'b0;
            r_div     <= '0;
            r_bitCnt  <= '0;
            r_phase   <= 1'b0;
            r_holdArm <= 1'b0;
            r_csN     <= 1'b1;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_rdy     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_nState;
            r_word    <= w_nWord;
            r_eof     <= w_nEof;
            r_div     <= w_nDiv;
            r_bitCnt  <= w_nBitCnt;
            r_phase   <= w_nPhase;
            r_holdArm <= (r_state == HOLD);
            r_csN     <= (w_nState == IDLE);
            r_sclk    <= w_nSclk;
            r_mosi    <= w_nMosi;
            r_rdy     <= (w_nState == IDLE) || (w_nState == NEXT);
            r_busy    <= (w_nState != IDLE);
            r_done    <= (r_state == HOLD) && (w_nState == IDLE);
        end
    end

    assign dma_rdy    = r_rdy;
    assign spi_cs_n   = r_csN;
    assign spi_sclk   = r_sclk;
    assign spi_mosi   = r_mosi;
    assign busy       = r_busy;
    assign frame_done = r_done;

endmodule
